// File: rtl/sdnet_ingress_shim.sv
// sdnet_ingress_shim
//   Glue between the NIC input stream and a generated SDNet ingress core.
//   - Stream path: combinational pass-through. An SOP beat is held back
//     while the metadata credits are used up (in-flight + buffered >= depth).
//   - core_meta_in_valid pulses on each accepted SOP beat and carries the
//     params value live in that cycle.
//   - Core metadata-out goes into a FIFO with registered outputs, drained
//     with a meta_out_valid/meta_out_ready handshake.
//   - Extern events are acknowledged ACK_LAT cycles after the request,
//     one shift register per channel.
//   - meta_err is sticky: metadata came back while nothing was in flight.
//   Optional macro SDNET_SHIM_STATS_EN builds the stat_* counters
//   (SOPs, FIFO pops, stalled SOP cycles). Without it they are tied to 0.
// Ports
//   clock, reset (synchronous, active high)
//   net_in_*      upstream AXI-Stream (valid/ready/data/keep/last)
//   core_in_*     AXI-Stream to the core
//   params        runtime parameter bundle
//   core_meta_in_valid/params   SOP metadata to the core
//   core_meta_out_valid/bits    metadata result from the core
//   meta_out_valid/ready/bits   buffered metadata result
//   evt_req_valid / evt_resp_valid   event strobes and acks
//   meta_err, stat_pkts, stat_meta, stat_stall
module sdnet_ingress_shim #(
  parameter int TDATA_W    = 512,
  parameter int PARAM_W    = 144,
  parameter int META_W     = 153,
  parameter int NUM_EVENTS = 3,
  parameter int ACK_LAT    = 1,
  parameter int META_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  net_in_valid,
  output logic                  net_in_ready,
  input  logic [TDATA_W-1:0]    net_in_data,
  input  logic [TDATA_W/8-1:0]  net_in_keep,
  input  logic                  net_in_last,
  output logic                  core_in_valid,
  input  logic                  core_in_ready,
  output logic [TDATA_W-1:0]    core_in_data,
  output logic [TDATA_W/8-1:0]  core_in_keep,
  output logic                  core_in_last,
  input  logic [PARAM_W-1:0]    params,
  output logic                  core_meta_in_valid,
  output logic [PARAM_W-1:0]    core_meta_in_params,
  input  logic                  core_meta_out_valid,
  input  logic [META_W-1:0]     core_meta_out_bits,
  output logic                  meta_out_valid,
  input  logic                  meta_out_ready,
  output logic [META_W-1:0]     meta_out_bits,
  input  logic [NUM_EVENTS-1:0] evt_req_valid,
  output logic [NUM_EVENTS-1:0] evt_resp_valid,
  output logic                  meta_err,
  output logic [31:0]           stat_pkts,
  output logic [31:0]           stat_meta,
  output logic [31:0]           stat_stall
);
  localparam int AW = $clog2(META_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_START, ST_WAIT_EOP} state_t;
  state_t r_state, w_state_nxt;

  logic          w_accept, w_sop, w_block, w_push, w_pop, w_full;
  logic [CW:0]   w_credit_used;
  logic [CW-1:0] r_inflight, r_count;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [META_W-1:0] r_mem [META_DEPTH];
  logic          r_meta_err;
  logic [ACK_LAT-1:0][NUM_EVENTS-1:0] r_evt_sr;

  // Credit check only gates SOP beats; a packet in progress is never stalled.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_block  = (r_state == ST_START) && (w_credit_used >= (CW+1)'(META_DEPTH));
  assign w_accept = net_in_valid && core_in_ready && !w_block;

  assign core_in_valid = net_in_valid && !w_block;
  assign net_in_ready  = core_in_ready && !w_block;
  assign core_in_data  = net_in_data;
  assign core_in_keep  = net_in_keep;
  assign core_in_last  = net_in_last;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_START;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sop       = 1'b0;
    case (r_state)
      ST_START: if (w_accept) begin
        w_sop = 1'b1;
        if (!net_in_last) w_state_nxt = ST_WAIT_EOP;
      end
      ST_WAIT_EOP: if (w_accept && net_in_last) w_state_nxt = ST_START;
      default: w_state_nxt = ST_START;
    endcase
  end

  assign core_meta_in_valid  = w_sop;
  assign core_meta_in_params = w_sop ? params : '0;

  // In-flight tracking; an underflow is flagged instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= '0;
      r_meta_err <= 1'b0;
    end else if (w_sop && !core_meta_out_valid) begin
      r_inflight <= r_inflight + CW'(1);
    end else if (!w_sop && core_meta_out_valid) begin
      if (r_inflight == '0) r_meta_err <= 1'b1;
      else                  r_inflight <= r_inflight - CW'(1);
    end
  end
  assign meta_err = r_meta_err;

  // Metadata FIFO: outputs come straight from registers, no write bypass.
  assign w_full = (r_count == CW'(META_DEPTH));
  assign w_push = core_meta_out_valid && !w_full;
  assign w_pop  = (r_count != '0) && meta_out_ready;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= core_meta_out_bits;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
  assign meta_out_valid = (r_count != '0);
  assign meta_out_bits  = r_mem[r_rd_ptr];

  // Event acks: fixed delay line, stage k holds requests from k+1 cycles ago.
  always_ff @(posedge clock) begin
    if (reset) r_evt_sr <= '0;
    else begin
      r_evt_sr[0] <= evt_req_valid;
      for (int k = 1; k < ACK_LAT; k++) r_evt_sr[k] <= r_evt_sr[k-1];
    end
  end
  assign evt_resp_valid = r_evt_sr[ACK_LAT-1];

`ifdef SDNET_SHIM_STATS_EN
  logic [31:0] r_stat_pkts, r_stat_meta, r_stat_stall;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_pkts  <= '0;
      r_stat_meta  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_sop)                   r_stat_pkts  <= r_stat_pkts + 32'd1;
      if (w_pop)                   r_stat_meta  <= r_stat_meta + 32'd1;
      if (net_in_valid && w_block) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end
  assign stat_pkts  = r_stat_pkts;
  assign stat_meta  = r_stat_meta;
  assign stat_stall = r_stat_stall;
`else
  assign stat_pkts  = '0;
  assign stat_meta  = '0;
  assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_sdnet_ingress_shim.sv
// Scoreboard bench for sdnet_ingress_shim (ACK_LAT=3, META_DEPTH=4).
// Stimulus pushes expected SOP params, metadata results and event acks
// into queues; a negedge monitor pops and compares whenever the DUT
// presents them. A few level checks (backpressure, meta_err, reset state)
// are made directly by the stimulus.
module tb_sdnet_ingress_shim;
  localparam int TW = 512, PW = 144, MW = 153, NE = 3, AL = 3, MD = 4;

  logic clock, reset;
  logic net_in_valid, net_in_ready, net_in_last;
  logic [TW-1:0] net_in_data, core_in_data;
  logic [TW/8-1:0] net_in_keep, core_in_keep;
  logic core_in_valid, core_in_ready, core_in_last;
  logic [PW-1:0] params, core_meta_in_params;
  logic core_meta_in_valid, core_meta_out_valid;
  logic [MW-1:0] core_meta_out_bits, meta_out_bits;
  logic meta_out_valid, meta_out_ready;
  logic [NE-1:0] evt_req_valid, evt_resp_valid;
  logic meta_err;
  logic [31:0] stat_pkts, stat_meta, stat_stall;

  sdnet_ingress_shim #(.TDATA_W(TW), .PARAM_W(PW), .META_W(MW), .NUM_EVENTS(NE),
                       .ACK_LAT(AL), .META_DEPTH(MD)) dut (
    .clock(clock), .reset(reset),
    .net_in_valid(net_in_valid), .net_in_ready(net_in_ready), .net_in_data(net_in_data),
    .net_in_keep(net_in_keep), .net_in_last(net_in_last),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
    .core_in_keep(core_in_keep), .core_in_last(core_in_last),
    .params(params), .core_meta_in_valid(core_meta_in_valid),
    .core_meta_in_params(core_meta_in_params),
    .core_meta_out_valid(core_meta_out_valid), .core_meta_out_bits(core_meta_out_bits),
    .meta_out_valid(meta_out_valid), .meta_out_ready(meta_out_ready),
    .meta_out_bits(meta_out_bits),
    .evt_req_valid(evt_req_valid), .evt_resp_valid(evt_resp_valid),
    .meta_err(meta_err), .stat_pkts(stat_pkts), .stat_meta(stat_meta),
    .stat_stall(stat_stall)
  );

  typedef struct { int cyc; logic [NE-1:0] val; } evt_t;
  logic [PW-1:0] q_par[$];
  logic [MW-1:0] q_meta[$];
  evt_t          q_evt[$];

  int vectors = 0, miscompares = 0, cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [255:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h with nothing expected", nm, act);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (core_meta_in_valid) begin
        if (q_par.size() == 0) unexpected("meta_in_pulse", core_meta_in_params);
        else chk("meta_in_params", core_meta_in_params, q_par.pop_front());
      end
      if (meta_out_valid && meta_out_ready) begin
        if (q_meta.size() == 0) unexpected("meta_out", meta_out_bits);
        else chk("meta_out_bits", meta_out_bits, q_meta.pop_front());
      end
      if (evt_resp_valid != '0) begin
        if (q_evt.size() == 0) unexpected("evt_resp", evt_resp_valid);
        else begin
          evt_t e;
          e = q_evt.pop_front();
          chk("evt_val", evt_resp_valid, e.val);
          chk("evt_cyc", cyc, e.cyc);
        end
      end
    end
  end

  task automatic sop_beat(input logic [PW-1:0] p, input logic last);
    net_in_valid = 1'b1; net_in_last = last; params = p;
    net_in_data = {16{p[31:0]}};
    q_par.push_back(p);
  endtask

  task automatic ret_meta(input logic [MW-1:0] m);
    core_meta_out_valid = 1'b1; core_meta_out_bits = m;
    q_meta.push_back(m);
    step();
    core_meta_out_valid = 1'b0;
  endtask

  task automatic drain();
    meta_out_ready = 1'b1;
    for (int i = 0; i < 20 && q_meta.size() != 0; i++) step();
    chk("drain_empty", q_meta.size(), 0);
  endtask

  int s0;

  initial begin
    reset = 1'b1; net_in_valid = 0; net_in_last = 0; net_in_data = '0; net_in_keep = '1;
    core_in_ready = 1'b1; params = '0; core_meta_out_valid = 0; core_meta_out_bits = '0;
    meta_out_ready = 1'b0; evt_req_valid = '0;
    repeat (3) step();
    chk("rst_meta_out_valid", meta_out_valid, 0);
    chk("rst_evt_resp", evt_resp_valid, 0);
    chk("rst_meta_err", meta_err, 0);
    chk("rst_stat_pkts", stat_pkts, 0);
    chk("rst_stat_stall", stat_stall, 0);
    reset = 1'b0;
    step();

    // Single-beat packet; metadata two cycles after SOP, visible next cycle.
    meta_out_ready = 1'b1;
    sop_beat(144'hA1A1_0001, 1'b1);
    chk("pass_data", core_in_data[31:0], 32'hA1A1_0001);
    step(); net_in_valid = 0;
    step();
    core_meta_out_valid = 1'b1; core_meta_out_bits = 153'h1_0000_00AA;
    q_meta.push_back(153'h1_0000_00AA);
    step(); core_meta_out_valid = 1'b0;
    chk("t1_meta_valid", meta_out_valid, 1);
    chk("t1_meta_bits", meta_out_bits, 153'h1_0000_00AA);
    step();

    // Three-beat packet, params change mid-packet: single pulse with beat-1 params.
    sop_beat(144'hB2B2_0002, 1'b0);
    step(); params = 144'hDEAD_0003;
    step(); net_in_last = 1'b1;
    step(); net_in_valid = 0;
    ret_meta(153'h2_0000_00BB);
    step();

    // Credit exhaustion with downstream stalled.
    meta_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sop_beat(144'hC000 + 144'(k), 1'b1);
      step();
    end
    net_in_valid = 0;
    for (int k = 0; k < 4; k++) ret_meta(153'h3_0000_0C00 + 153'(k));
    s0 = stat_stall;
    net_in_valid = 1'b1; net_in_last = 1'b1; params = 144'hD9D9_0009;
    chk("blk_ready", net_in_ready, 0);
    chk("blk_core_valid", core_in_valid, 0);
    repeat (3) step();
    chk("blk_ready_held", net_in_ready, 0);
`ifdef SDNET_SHIM_STATS_EN
    chk("stat_stall", stat_stall - s0, 3);
    chk("stat_pkts", stat_pkts, 6);
`else
    chk("stat_stall_off", stat_stall, 0);
    chk("stat_pkts_off", stat_pkts, 0);
`endif
    q_par.push_back(144'hD9D9_0009);
    meta_out_ready = 1'b1;
    step(); meta_out_ready = 1'b0;
    chk("release_ready", net_in_ready, 1);
    step(); net_in_valid = 0;
    ret_meta(153'h4_0000_00DD);
    drain();
`ifdef SDNET_SHIM_STATS_EN
    chk("stat_meta", stat_meta, 7);
`endif

    // Events, ACK_LAT=3, back-to-back.
    evt_req_valid = 3'b101; q_evt.push_back('{cyc + 3, 3'b101});
    step();
    evt_req_valid = 3'b010; q_evt.push_back('{cyc + 3, 3'b010});
    step();
    evt_req_valid = '0;
    repeat (4) step();
    chk("evt_q_empty", q_evt.size(), 0);

    // Metadata with nothing in flight: sticky error, entry still buffered.
    meta_out_ready = 1'b1;
    chk("err_before", meta_err, 0);
    ret_meta(153'h5_0000_00EE);
    chk("err_set", meta_err, 1);
    repeat (3) step();
    chk("err_sticky", meta_err, 1);
    chk("err_entry_popped", q_meta.size(), 0);

    // Reset in WAIT_EOP with two FIFO entries and a pending ack.
    meta_out_ready = 1'b0;
    sop_beat(144'hE1E1_0010, 1'b0);
    step(); net_in_valid = 0;
    core_meta_out_valid = 1'b1; core_meta_out_bits = 153'h6_0000_0001;
    step(); core_meta_out_bits = 153'h6_0000_0002;
    step(); core_meta_out_valid = 1'b0;
    chk("pre_rst_valid", meta_out_valid, 1);
    evt_req_valid = 3'b111;
    step(); evt_req_valid = '0;
    reset = 1'b1;
    step(); step();
    chk("rst2_meta_valid", meta_out_valid, 0);
    chk("rst2_meta_err", meta_err, 0);
    chk("rst2_evt", evt_resp_valid, 0);
    reset = 1'b0;
    repeat (4) step();
    chk("rst2_valid_after", meta_out_valid, 0);
    ret_meta(153'h7_0000_0077);
    chk("rst2_inflight_zero", meta_err, 1);
    sop_beat(144'hF1F1_0011, 1'b0);
    step(); params = 144'hF2F2_0012; net_in_last = 1'b1;
    step(); net_in_valid = 0;
    ret_meta(153'h7_0000_0078);
    drain();
    step();
    chk("par_q_empty", q_par.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
